cnn_window_feeder: RTL and testbench

- Upstream stage of the mini CNN compute unit.
- Buffers one signed 8-bit raster frame and holds a WINDOW×WINDOW kernel.
- For every convolution window position, drives the compute unit's byte-serial load protocol (load_enable, 18 data bytes, start pulse), then waits for the unit to finish before moving to the next window.
- Reports the current window coordinates and a frame-done pulse.

---
 rtl/cnn_window_feeder.sv | 164 ++++++++++++++++
 tb/tb_cnn_window_feeder.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_window_feeder.sv
// Upstream feeder for the mini CNN compute unit: buffers one raster frame and a
// kernel, then streams every convolution window through the unit's load protocol.
module cnn_window_feeder #(
    parameter int WINDOW = 3,
    parameter int IMG_W  = 6,
    parameter int IMG_H  = 6,
    parameter int STRIDE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_valid,
    output logic       pix_ready,
    input  logic [7:0] pix_data,
    input  logic       kern_we,
    input  logic [7:0] kern_addr,
    input  logic [7:0] kern_data,
    output logic       cnn_load_enable,
    output logic [7:0] cnn_data,
    output logic       cnn_start,
    input  logic       cnn_busy,
    output logic [7:0] win_row,
    output logic [7:0] win_col,
    output logic       frame_done
);
    localparam int NN    = WINDOW * WINDOW;
    localparam int NPIX  = IMG_W * IMG_H;
    localparam int OUT_W = (IMG_W - WINDOW) / STRIDE + 1;
    localparam int OUT_H = (IMG_H - WINDOW) / STRIDE + 1;
    localparam int CW    = $clog2(2 * NN);
    localparam int PW    = $clog2(NPIX);
    localparam int KW    = $clog2(NN);

    localparam logic [2:0] S_FILL      = 3'd0;
    localparam logic [2:0] S_ARM       = 3'd1;
    localparam logic [2:0] S_STREAM    = 3'd2;
    localparam logic [2:0] S_START     = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;

    localparam logic [CW-1:0] CNT_LAST  = CW'(2 * NN - 1);
    localparam logic [CW-1:0] CNT_NN    = CW'(NN);
    localparam logic [PW-1:0] PTR_LAST  = PW'(NPIX - 1);
    localparam logic [7:0]    KADDR_LIM = 8'(NN);
    localparam logic [7:0]    COL_LAST  = 8'(OUT_W - 1);
    localparam logic [7:0]    ROW_LAST  = 8'(OUT_H - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_ptr;
    logic [7:0]    r_frame [NPIX];
    logic [7:0]    r_kern  [NN];
    logic [7:0]    r_win_row;
    logic [7:0]    r_win_col;
    logic [7:0]    r_cnn_data;
    logic          r_pix_ready;
    logic          r_load_en;
    logic          r_start;
    logic          r_frame_done;

    logic          w_pix_xfer;
    logic          w_last_win;
    logic [CW-1:0] w_sel;
    logic [CW-1:0] w_row_off;
    logic [CW-1:0] w_col_off;
    logic [PW-1:0] w_pix_idx;
    logic [KW-1:0] w_kern_idx;
    logic [7:0]    w_byte;

    assign w_pix_xfer = pix_valid & r_pix_ready;
    assign w_last_win = (r_win_col == COL_LAST) && (r_win_row == ROW_LAST);

    // Sequencer next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_pix_xfer && (r_ptr == PTR_LAST)) w_state_nxt = S_ARM;
                else                                   w_state_nxt = S_FILL;
            end
            S_ARM:    w_state_nxt = S_STREAM;
            S_STREAM: begin
                if (r_cnt == CNT_LAST) w_state_nxt = S_START;
                else                   w_state_nxt = S_STREAM;
            end
            S_START:  w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (cnn_busy) w_state_nxt = S_WAIT_DONE;
                else          w_state_nxt = S_WAIT_BUSY;
            end
            S_WAIT_DONE: begin
                if (cnn_busy)        w_state_nxt = S_WAIT_DONE;
                else if (w_last_win) w_state_nxt = S_FILL;
                else                 w_state_nxt = S_ARM;
            end
            default:  w_state_nxt = S_FILL;
        endcase
    end

    // Byte fetched one cycle ahead so cnn_data can be a plain register
    always_comb begin
        w_sel      = (r_state == S_ARM) ? {CW{1'b0}} : r_cnt + CW'(1);
        w_row_off  = w_sel / CW'(WINDOW);
        w_col_off  = w_sel % CW'(WINDOW);
        w_pix_idx  = (PW'(r_win_row) * PW'(STRIDE) + PW'(w_row_off)) * PW'(IMG_W)
                   + PW'(r_win_col) * PW'(STRIDE) + PW'(w_col_off);
        w_kern_idx = KW'(w_sel - CNT_NN);
        if (w_sel < CNT_NN) w_byte = r_frame[w_pix_idx];
        else                w_byte = r_kern[w_kern_idx];
    end

    // Frame and kernel storage; contents survive reset
    always_ff @(posedge clk) begin
        if (w_pix_xfer) r_frame[r_ptr] <= pix_data;
        if (kern_we && (r_state == S_FILL) && (kern_addr < KADDR_LIM))
            r_kern[kern_addr[KW-1:0]] <= kern_data;
    end

    // Control state and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_FILL;
            r_cnt        <= {CW{1'b0}};
            r_ptr        <= {PW{1'b0}};
            r_win_row    <= 8'd0;
            r_win_col    <= 8'd0;
            r_cnn_data   <= 8'd0;
            r_pix_ready  <= 1'b1;
            r_load_en    <= 1'b0;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pix_ready  <= (w_state_nxt == S_FILL);
            r_load_en    <= (w_state_nxt == S_ARM);
            r_start      <= (w_state_nxt == S_START);
            r_frame_done <= (r_state == S_WAIT_DONE) && !cnn_busy && w_last_win;
            if (w_pix_xfer) r_ptr <= (r_ptr == PTR_LAST) ? {PW{1'b0}} : r_ptr + PW'(1);
            if (r_state == S_STREAM) r_cnt <= r_cnt + CW'(1);
            else                     r_cnt <= {CW{1'b0}};
            if ((r_state == S_ARM) || ((r_state == S_STREAM) && (r_cnt != CNT_LAST)))
                r_cnn_data <= w_byte;
            if ((r_state == S_WAIT_DONE) && !cnn_busy) begin
                if (r_win_col != COL_LAST) begin
                    r_win_col <= r_win_col + 8'd1;
                end else if (r_win_row != ROW_LAST) begin
                    r_win_col <= 8'd0;
                    r_win_row <= r_win_row + 8'd1;
                end else begin
                    r_win_col <= 8'd0;
                    r_win_row <= 8'd0;
                end
            end
        end
    end

    assign pix_ready       = r_pix_ready;
    assign cnn_load_enable = r_load_en;
    assign cnn_data        = r_cnn_data;
    assign cnn_start       = r_start;
    assign win_row         = r_win_row;
    assign win_col         = r_win_col;
    assign frame_done      = r_frame_done;
endmodule

// File: tb/tb_cnn_window_feeder.sv
// Scoreboard bench: instance A uses the default 6x6/stride-1 geometry, instance B a
// 5x5/stride-2 geometry; each has its own compute-unit model and monitor.
module tb_cnn_window_feeder;
    localparam int W  = 3;
    localparam int NN = 9;

    int checks   = 0;
    int failures = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_reset, a_pv, a_pr, a_kwe, a_le, a_st, a_busy, a_fd;
    logic [7:0] a_pd, a_ka, a_kd, a_cd, a_wr, a_wc;
    logic       b_reset, b_pv, b_pr, b_kwe, b_le, b_st, b_busy, b_fd;
    logic [7:0] b_pd, b_ka, b_kd, b_cd, b_wr, b_wc;

    cnn_window_feeder u_dut_a (
        .clk(clk), .reset(a_reset), .pix_valid(a_pv), .pix_ready(a_pr), .pix_data(a_pd),
        .kern_we(a_kwe), .kern_addr(a_ka), .kern_data(a_kd), .cnn_load_enable(a_le),
        .cnn_data(a_cd), .cnn_start(a_st), .cnn_busy(a_busy), .win_row(a_wr),
        .win_col(a_wc), .frame_done(a_fd)
    );

    cnn_window_feeder #(.WINDOW(3), .IMG_W(5), .IMG_H(5), .STRIDE(2)) u_dut_b (
        .clk(clk), .reset(b_reset), .pix_valid(b_pv), .pix_ready(b_pr), .pix_data(b_pd),
        .kern_we(b_kwe), .kern_addr(b_ka), .kern_data(b_kd), .cnn_load_enable(b_le),
        .cnn_data(b_cd), .cnn_start(b_st), .cnn_busy(b_busy), .win_row(b_wr),
        .win_col(b_wc), .frame_done(b_fd)
    );

    logic [7:0] a_frame [36];
    logic [7:0] a_kern  [NN];
    logic [7:0] b_frame [25];
    logic [7:0] b_kern  [NN];
    int a_expr[$], a_expc[$], b_expr[$], b_expc[$];
    int a_expb[$], b_expb[$];
    int a_ph = 0, b_ph = 0, a_er = 0, a_ec = 0, b_er = 0, b_ec = 0;
    int a_fd_cnt = 0, b_fd_cnt = 0, a_bcnt, b_bcnt;
    bit b_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Compute-unit models: busy rises two cycles after start and lasts nine cycles
    always @(posedge clk or negedge a_reset)
        if (!a_reset) begin a_bcnt <= 0; a_busy <= 1'b0; end
        else begin
            if (a_st) a_bcnt <= 10; else if (a_bcnt > 0) a_bcnt <= a_bcnt - 1;
            a_busy <= (a_bcnt >= 1 && a_bcnt <= 9);
        end
    always @(posedge clk or negedge b_reset)
        if (!b_reset) begin b_bcnt <= 0; b_busy <= 1'b0; end
        else begin
            if (b_st) b_bcnt <= 10; else if (b_bcnt > 0) b_bcnt <= b_bcnt - 1;
            b_busy <= (b_bcnt >= 1 && b_bcnt <= 9);
        end

    // Reference windows: slide the window over the frame in raster order
    task automatic push_a();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_expr.push_back(r);
                a_expc.push_back(c);
                for (int i = 0; i < W; i++)
                    for (int j = 0; j < W; j++) a_expb.push_back(int'(a_frame[(r + i) * 6 + c + j]));
                for (int k = 0; k < NN; k++) a_expb.push_back(int'(a_kern[k]));
            end
    endtask

    task automatic push_b();
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                b_expr.push_back(r);
                b_expc.push_back(c);
                for (int i = 0; i < W; i++)
                    for (int j = 0; j < W; j++) b_expb.push_back(int'(b_frame[(r * 2 + i) * 5 + c * 2 + j]));
                for (int k = 0; k < NN; k++) b_expb.push_back(int'(b_kern[k]));
            end
    endtask

    // Monitor A: one byte per cycle after load_enable, start right after byte 17
    initial forever begin
        @(negedge clk);
        if (!a_reset) a_ph = 0;
        else begin
            check("a_le_and_start", int'(a_le & a_st), 0);
            if (a_fd) begin
                a_fd_cnt++;
                check("a_fd_pix_ready", a_pr, 1);
                check("a_fd_windows_left", a_expr.size(), 0);
            end
            if (a_ph == 2 * NN + 1) begin
                check("a_start", a_st, 1);
                a_ph = 0;
            end else if (a_ph > 0) begin
                check("a_le_in_stream", a_le, 0);
                check("a_win_row", a_wr, a_er);
                check("a_win_col", a_wc, a_ec);
                if (a_expb.size() == 0) check("a_exp_bytes_left", a_expb.size(), 1);
                else check("a_byte", a_cd, a_expb.pop_front());
                a_ph++;
            end else if (a_le) begin
                if (a_expr.size() == 0) begin
                    check("a_exp_windows_left", a_expr.size(), 1);
                    a_er = -1; a_ec = -1;
                end else begin
                    a_er = a_expr.pop_front();
                    a_ec = a_expc.pop_front();
                end
                check("a_win_row_arm", a_wr, a_er);
                check("a_win_col_arm", a_wc, a_ec);
                a_ph = 1;
            end
        end
    end

    // Monitor B
    initial forever begin
        @(negedge clk);
        if (!b_reset) b_ph = 0;
        else begin
            check("b_le_and_start", int'(b_le & b_st), 0);
            if (b_fd) begin
                b_fd_cnt++;
                check("b_fd_pix_ready", b_pr, 1);
                check("b_fd_windows_left", b_expr.size(), 0);
            end
            if (b_ph == 2 * NN + 1) begin
                check("b_start", b_st, 1);
                b_ph = 0;
            end else if (b_ph > 0) begin
                check("b_le_in_stream", b_le, 0);
                check("b_win_row", b_wr, b_er);
                check("b_win_col", b_wc, b_ec);
                if (b_expb.size() == 0) check("b_exp_bytes_left", b_expb.size(), 1);
                else check("b_byte", b_cd, b_expb.pop_front());
                b_ph++;
            end else if (b_le) begin
                if (b_expr.size() == 0) begin
                    check("b_exp_windows_left", b_expr.size(), 1);
                    b_er = -1; b_ec = -1;
                end else begin
                    b_er = b_expr.pop_front();
                    b_ec = b_expc.pop_front();
                end
                check("b_win_row_arm", b_wr, b_er);
                check("b_win_col_arm", b_wc, b_ec);
                b_ph = 1;
            end
        end
    end

    task automatic feed_a(input bit gaps);
        for (int k = 0; k < 36; k++) begin
            bit done;
            int t;
            done = 1'b0;
            t = 0;
            while (!done && t < 5000) begin
                @(negedge clk);
                a_pv = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                a_pd = a_frame[k];
                done = a_pv && a_pr;
                t++;
            end
            check("a_pixel_accepted", int'(done), 1);
        end
    endtask

    task automatic feed_b();
        for (int k = 0; k < 25; k++) begin
            bit done;
            int t;
            done = 1'b0;
            t = 0;
            while (!done && t < 5000) begin
                @(negedge clk);
                b_pv = 1'($urandom_range(0, 1));
                b_pd = b_frame[k];
                done = b_pv && b_pr;
                t++;
            end
            check("b_pixel_accepted", int'(done), 1);
        end
    endtask

    task automatic kern_write_a(input logic [7:0] addr, input logic [7:0] data);
        @(negedge clk);
        a_kwe = 1'b1; a_ka = addr; a_kd = data;
        @(negedge clk);
        a_kwe = 1'b0;
    endtask

    task automatic wait_fd_a(input int n);
        int t;
        t = 0;
        while (a_fd_cnt < n && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check("a_frames_done", a_fd_cnt, n);
    endtask

    // Attempt a kernel overwrite while window (0,0) is streaming
    task automatic poke_a();
        int t;
        t = 0;
        while (a_ph != 5 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check("a_poke_in_stream", a_ph, 5);
        a_ka = 8'd0; a_kd = 8'hFB; a_kwe = 1'b1;
        repeat (3) @(negedge clk);
        a_kwe = 1'b0;
    endtask

    // Instance B stimulus
    initial begin
        int t;
        b_reset = 1'b0; b_pv = 1'b0; b_pd = 8'd0; b_kwe = 1'b0; b_ka = 8'd0; b_kd = 8'd0;
        repeat (2) @(negedge clk);
        b_reset = 1'b1;
        for (int k = 0; k < NN; k++) begin
            b_kern[k] = 8'($urandom);
            @(negedge clk);
            b_kwe = 1'b1; b_ka = 8'(k); b_kd = b_kern[k];
        end
        @(negedge clk);
        b_kwe = 1'b0;
        for (int k = 0; k < 25; k++) b_frame[k] = 8'(k);
        feed_b();
        push_b();
        @(negedge clk);
        b_pv = 1'b0;
        t = 0;
        while (b_fd_cnt < 1 && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check("b_frames_done", b_fd_cnt, 1);
        b_done = 1'b1;
    end

    // Instance A stimulus
    initial begin
        int t;
        a_reset = 1'b0; a_pv = 1'b0; a_pd = 8'd0; a_kwe = 1'b0; a_ka = 8'd0; a_kd = 8'd0;
        #12;
        check("rst_pix_ready", a_pr, 1);
        check("rst_load_en", a_le, 0);
        check("rst_cnn_data", a_cd, 0);
        check("rst_start", a_st, 0);
        check("rst_win_row", a_wr, 0);
        check("rst_win_col", a_wc, 0);
        check("rst_frame_done", a_fd, 0);
        @(negedge clk);
        a_reset = 1'b1;

        for (int k = 0; k < NN; k++) begin
            a_kern[k] = 8'd1;
            kern_write_a(8'(k), 8'd1);
        end
        kern_write_a(8'd9, 8'h55);
        for (int k = 0; k < 36; k++) a_frame[k] = 8'(k);

        // Frames 1 and 2 back to back: pix_valid stays high across frame 1's processing
        fork
            begin
                feed_a(1'b0);
                push_a();
                for (int k = 0; k < 36; k++) a_frame[k] = 8'($urandom);
                feed_a(1'b0);
                push_a();
                @(negedge clk);
                a_pv = 1'b0;
            end
            poke_a();
        join
        wait_fd_a(2);

        // Frame 3: asynchronous reset during byte 5 of window (0,2)
        for (int k = 0; k < 36; k++) a_frame[k] = 8'($urandom_range(1, 255));
        feed_a(1'b1);
        push_a();
        @(negedge clk);
        a_pv = 1'b0;
        t = 0;
        while (!(a_ph == 7 && a_ec == 2) && t < 3000) begin
            @(negedge clk); #1;
            t++;
        end
        check("a_reset_point_ph", a_ph, 7);
        check("a_reset_point_col", a_wc, 2);
        a_reset = 1'b0;
        #1;
        check("mid_rst_pix_ready", a_pr, 1);
        check("mid_rst_load_en", a_le, 0);
        check("mid_rst_cnn_data", a_cd, 0);
        check("mid_rst_start", a_st, 0);
        check("mid_rst_win_row", a_wr, 0);
        check("mid_rst_win_col", a_wc, 0);
        check("mid_rst_frame_done", a_fd, 0);
        a_expr.delete(); a_expc.delete(); a_expb.delete();
        @(negedge clk);
        a_reset = 1'b1;
        @(negedge clk);
        check("post_rst_pix_ready", a_pr, 1);

        // Frame 4: fresh random kernel, random pixel gaps
        for (int k = 0; k < NN; k++) begin
            a_kern[k] = 8'($urandom);
            kern_write_a(8'(k), a_kern[k]);
        end
        kern_write_a(8'(NN + $urandom_range(0, 200)), 8'hA5);
        for (int k = 0; k < 36; k++) a_frame[k] = 8'($urandom);
        feed_a(1'b1);
        push_a();
        @(negedge clk);
        a_pv = 1'b0;
        wait_fd_a(3);

        t = 0;
        while (!b_done && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("b_finished", int'(b_done), 1);
        check("a_bytes_leftover", a_expb.size(), 0);
        check("b_bytes_leftover", b_expb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog time=%0t limit=900000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
